// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer
// Bridges the hps_io ioctl download port to the game core's ROM write port.
// ROM bytes (ROM_INDEX) are queued in a small FIFO and handed to the core over
// a rom_req/rom_ack handshake; ioctl_wait throttles hps_io as the FIFO fills.
// Index TNO_INDEX writes latch the title number. The core is held in reset
// while a download runs, while the FIFO drains, and for HOLD_CYC cycles after.
// Ports:
//   clk_sys, RESET_N          clock, asynchronous active-low reset
//   ioctl_download/wr/addr/dout/index, ioctl_wait   hps_io download side
//   rom_req, rom_ack, rom_addr, rom_data            core ROM write side
//   tno, core_reset                                 title number, core reset
//   checksum, overflow                              diagnostics
module rom_dl_sequencer #(
    parameter int          DEPTH     = 4,
    parameter int          HOLD_CYC  = 16,
    parameter logic [7:0]  ROM_INDEX = 8'd0,
    parameter logic [7:0]  TNO_INDEX = 8'd1
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic        rom_req,
    input  logic        rom_ack,
    output logic [24:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic [3:0]  tno,
    output logic        core_reset,
    output logic [7:0]  checksum,
    output logic        overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    state_t         state_r, state_next_s;
    logic           dl_prev_r;
    logic [HW-1:0]  hold_cnt_r, hold_next_s;
    logic [PW-1:0]  wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
    logic [CW-1:0]  count_r, count_next_s;
    logic [24:0]    mem_addr_r [DEPTH];
    logic [7:0]     mem_data_r [DEPTH];
    logic [24:0]    rom_addr_r, head_addr_next_s;
    logic [7:0]     rom_data_r, head_data_next_s;
    logic [3:0]     tno_r;
    logic           core_reset_r;
    logic [7:0]     checksum_r, checksum_next_s;
    logic           overflow_r, overflow_next_s;
    logic           ioctl_wait_r;

    logic rise_s, fall_s, start_s, rom_req_s, full_s;
    logic push_req_s, push_s, pop_s, drop_s;

    assign rise_s     = ~dl_prev_r & ioctl_download;
    assign fall_s     = dl_prev_r & ~ioctl_download;
    // A ROM-index rise restarts the load from any state and flushes the FIFO.
    assign start_s    = rise_s & (ioctl_index == ROM_INDEX);
    assign rom_req_s  = (count_r != CW'(0));
    assign full_s     = (count_r == CW'(DEPTH));
    assign pop_s      = rom_req_s & rom_ack & ~start_s;
    assign push_req_s = ioctl_wr & (ioctl_index == ROM_INDEX) & (state_r == ST_LOAD) & ~start_s;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_s     = push_req_s & (~full_s | pop_s);
    assign drop_s     = push_req_s & full_s & ~pop_s;

    // Sequencer next state and hold counter.
    always_comb begin
        state_next_s = state_r;
        hold_next_s  = hold_cnt_r;
        if (start_s) begin
            state_next_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_IDLE: state_next_s = ST_IDLE;
                ST_LOAD: begin
                    if (fall_s) begin
                        state_next_s = ST_DRAIN;
                    end else begin
                        state_next_s = ST_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (count_r == CW'(0)) begin
                        state_next_s = ST_HOLD;
                        hold_next_s  = HW'(HOLD_CYC);
                    end else begin
                        state_next_s = ST_DRAIN;
                    end
                end
                ST_HOLD: begin
                    // The counter value 1 is the last hold cycle; it reaches 0 on leaving.
                    if (hold_cnt_r <= HW'(1)) begin
                        state_next_s = ST_RUN;
                        hold_next_s  = HW'(0);
                    end else begin
                        hold_next_s  = hold_cnt_r - HW'(1);
                    end
                end
                ST_RUN:  state_next_s = ST_RUN;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy, head lookahead and diagnostics.
    always_comb begin
        wr_ptr_next_s    = wr_ptr_r;
        rd_ptr_next_s    = rd_ptr_r;
        count_next_s     = count_r;
        head_addr_next_s = rom_addr_r;
        head_data_next_s = rom_data_r;
        checksum_next_s  = checksum_r;
        overflow_next_s  = overflow_r;
        if (start_s) begin
            wr_ptr_next_s   = PW'(0);
            rd_ptr_next_s   = PW'(0);
            count_next_s    = CW'(0);
            checksum_next_s = 8'd0;
            overflow_next_s = 1'b0;
        end else begin
            wr_ptr_next_s   = wr_ptr_r + PW'(push_s);
            rd_ptr_next_s   = rd_ptr_r + PW'(pop_s);
            count_next_s    = count_r + CW'(push_s) - CW'(pop_s);
            checksum_next_s = pop_s ? (checksum_r + rom_data_r) : checksum_r;
            overflow_next_s = overflow_r | drop_s;
            // The byte being written becomes the head when it lands in the read slot.
            if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
                head_addr_next_s = ioctl_addr;
                head_data_next_s = ioctl_dout;
            end else begin
                head_addr_next_s = mem_addr_r[rd_ptr_next_s];
                head_data_next_s = mem_data_r[rd_ptr_next_s];
            end
        end
    end

    // State, FIFO storage and all registered outputs.
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r      <= ST_IDLE;
            dl_prev_r    <= 1'b0;
            hold_cnt_r   <= HW'(0);
            wr_ptr_r     <= PW'(0);
            rd_ptr_r     <= PW'(0);
            count_r      <= CW'(0);
            rom_addr_r   <= 25'd0;
            rom_data_r   <= 8'd0;
            tno_r        <= 4'd0;
            core_reset_r <= 1'b1;
            checksum_r   <= 8'd0;
            overflow_r   <= 1'b0;
            ioctl_wait_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_r[i] <= 25'd0;
                mem_data_r[i] <= 8'd0;
            end
        end else begin
            state_r      <= state_next_s;
            dl_prev_r    <= ioctl_download;
            hold_cnt_r   <= hold_next_s;
            wr_ptr_r     <= wr_ptr_next_s;
            rd_ptr_r     <= rd_ptr_next_s;
            count_r      <= count_next_s;
            rom_addr_r   <= head_addr_next_s;
            rom_data_r   <= head_data_next_s;
            core_reset_r <= (state_next_s != ST_RUN);
            checksum_r   <= checksum_next_s;
            overflow_r   <= overflow_next_s;
            ioctl_wait_r <= (count_next_s >= CW'(DEPTH - 1));
            if (ioctl_wr && (ioctl_index == TNO_INDEX)) begin
                tno_r <= ioctl_dout[3:0];
            end
            if (push_s) begin
                mem_addr_r[wr_ptr_r] <= ioctl_addr;
                mem_data_r[wr_ptr_r] <= ioctl_dout;
            end
        end
    end

    assign ioctl_wait = ioctl_wait_r;
    assign rom_req    = rom_req_s;
    assign rom_addr   = rom_addr_r;
    assign rom_data   = rom_data_r;
    assign tno        = tno_r;
    assign core_reset = core_reset_r;
    assign checksum   = checksum_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer: a vector table covers the load,
// title-latch and backpressure flows; hand sequences cover power-up,
// the hold-window timing and asynchronous reset mid-transfer.
module tb_rom_dl_sequencer;

    logic        clk_sys;
    logic        RESET_N;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic        ioctl_wait;
    logic        rom_req;
    logic        rom_ack;
    logic [24:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  tno;
    logic        core_reset;
    logic [7:0]  checksum;
    logic        overflow;

    int n_assert = 0;
    int n_fail   = 0;

    rom_dl_sequencer dut (
        .clk_sys        (clk_sys),
        .RESET_N        (RESET_N),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_wait     (ioctl_wait),
        .rom_req        (rom_req),
        .rom_ack        (rom_ack),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .tno            (tno),
        .core_reset     (core_reset),
        .checksum       (checksum),
        .overflow       (overflow)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        dl;
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  dout;
        logic [7:0]  idx;
        logic        ack;
        logic        e_req;
        logic        chk_head;
        logic [24:0] e_addr;
        logic [7:0]  e_data;
        logic        e_wait;
        logic        e_cr;
        logic [3:0]  e_tno;
        logic [7:0]  e_cs;
        logic        e_ov;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic dl, logic wr, logic [24:0] addr, logic [7:0] dout,
                                logic [7:0] idx, logic ack, logic e_req, logic chk_head,
                                logic [24:0] e_addr, logic [7:0] e_data, logic e_wait,
                                logic e_cr, logic [3:0] e_tno, logic [7:0] e_cs, logic e_ov);
        vec_t v;
        v.dl = dl; v.wr = wr; v.addr = addr; v.dout = dout; v.idx = idx; v.ack = ack;
        v.e_req = e_req; v.chk_head = chk_head; v.e_addr = e_addr; v.e_data = e_data;
        v.e_wait = e_wait; v.e_cr = e_cr; v.e_tno = e_tno; v.e_cs = e_cs; v.e_ov = e_ov;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            ioctl_download = vt[i].dl;
            ioctl_wr       = vt[i].wr;
            ioctl_addr     = vt[i].addr;
            ioctl_dout     = vt[i].dout;
            ioctl_index    = vt[i].idx;
            rom_ack        = vt[i].ack;
            step();
            chk($sformatf("v%0d_req", i), 32'(rom_req), 32'(vt[i].e_req));
            if (vt[i].chk_head) begin
                chk($sformatf("v%0d_addr", i), 32'(rom_addr), 32'(vt[i].e_addr));
                chk($sformatf("v%0d_data", i), 32'(rom_data), 32'(vt[i].e_data));
            end
            chk($sformatf("v%0d_wait", i), 32'(ioctl_wait), 32'(vt[i].e_wait));
            chk($sformatf("v%0d_core_reset", i), 32'(core_reset), 32'(vt[i].e_cr));
            chk($sformatf("v%0d_tno", i), 32'(tno), 32'(vt[i].e_tno));
            chk($sformatf("v%0d_checksum", i), 32'(checksum), 32'(vt[i].e_cs));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vt[i].e_ov));
        end
        ioctl_wr = 1'b0;
        rom_ack  = 1'b0;
    endtask

    // Counts edges until core_reset drops; release must come HOLD_CYC=16 edges in.
    task automatic wait_release(input string nm);
        int n;
        n = 0;
        while ((core_reset === 1'b1) && (n < 100)) begin
            step();
            n++;
        end
        chk(nm, 32'(n), 32'd16);
    endtask

    initial begin
        RESET_N        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        ioctl_index    = 8'd0;
        rom_ack        = 1'b0;

        //           dl   wr   addr      dout   idx    ack  req  hd   e_addr    e_data wait cr   tno   cs     ov
        // basic load, ack tied high
        vt.push_back(mk(1'b1,1'b0,25'h0,  8'h00,8'd0,1'b1,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b1,4'd0,8'h00,1'b0)); // 0
        vt.push_back(mk(1'b1,1'b1,25'h0,  8'h11,8'd0,1'b1,1'b1,1'b1,25'h0,  8'h11,1'b0,1'b1,4'd0,8'h00,1'b0)); // 1
        vt.push_back(mk(1'b1,1'b1,25'h1,  8'h22,8'd0,1'b1,1'b1,1'b1,25'h1,  8'h22,1'b0,1'b1,4'd0,8'h11,1'b0)); // 2
        vt.push_back(mk(1'b1,1'b1,25'h2,  8'h33,8'd0,1'b1,1'b1,1'b1,25'h2,  8'h33,1'b0,1'b1,4'd0,8'h33,1'b0)); // 3
        vt.push_back(mk(1'b0,1'b0,25'h0,  8'h00,8'd0,1'b1,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b1,4'd0,8'h66,1'b0)); // 4
        vt.push_back(mk(1'b0,1'b0,25'h0,  8'h00,8'd0,1'b0,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b1,4'd0,8'h66,1'b0)); // 5
        // title latch while running
        vt.push_back(mk(1'b1,1'b0,25'h0,  8'h00,8'd1,1'b0,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b0,4'd0,8'h66,1'b0)); // 6
        vt.push_back(mk(1'b1,1'b1,25'h0,  8'h02,8'd1,1'b0,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b0,4'd2,8'h66,1'b0)); // 7
        vt.push_back(mk(1'b0,1'b0,25'h0,  8'h00,8'd1,1'b0,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b0,4'd2,8'h66,1'b0)); // 8
        // backpressure, full push+pop, overflow, reload mid-hold
        vt.push_back(mk(1'b1,1'b0,25'h0,  8'h00,8'd0,1'b0,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b1,4'd2,8'h00,1'b0)); // 9
        vt.push_back(mk(1'b1,1'b1,25'h100,8'hA1,8'd0,1'b0,1'b1,1'b1,25'h100,8'hA1,1'b0,1'b1,4'd2,8'h00,1'b0)); // 10
        vt.push_back(mk(1'b1,1'b1,25'h101,8'hA2,8'd0,1'b0,1'b1,1'b1,25'h100,8'hA1,1'b0,1'b1,4'd2,8'h00,1'b0)); // 11
        vt.push_back(mk(1'b1,1'b1,25'h102,8'hA3,8'd0,1'b0,1'b1,1'b1,25'h100,8'hA1,1'b1,1'b1,4'd2,8'h00,1'b0)); // 12
        vt.push_back(mk(1'b1,1'b1,25'h103,8'hA4,8'd0,1'b0,1'b1,1'b1,25'h100,8'hA1,1'b1,1'b1,4'd2,8'h00,1'b0)); // 13
        vt.push_back(mk(1'b1,1'b1,25'h104,8'hA5,8'd0,1'b1,1'b1,1'b1,25'h101,8'hA2,1'b1,1'b1,4'd2,8'hA1,1'b0)); // 14
        vt.push_back(mk(1'b1,1'b1,25'h105,8'hA6,8'd0,1'b0,1'b1,1'b1,25'h101,8'hA2,1'b1,1'b1,4'd2,8'hA1,1'b1)); // 15
        vt.push_back(mk(1'b1,1'b0,25'h0,  8'h00,8'd0,1'b1,1'b1,1'b1,25'h102,8'hA3,1'b1,1'b1,4'd2,8'h43,1'b1)); // 16
        vt.push_back(mk(1'b1,1'b0,25'h0,  8'h00,8'd0,1'b1,1'b1,1'b1,25'h103,8'hA4,1'b0,1'b1,4'd2,8'hE6,1'b1)); // 17
        vt.push_back(mk(1'b1,1'b0,25'h0,  8'h00,8'd0,1'b1,1'b1,1'b1,25'h104,8'hA5,1'b0,1'b1,4'd2,8'h8A,1'b1)); // 18
        vt.push_back(mk(1'b1,1'b0,25'h0,  8'h00,8'd0,1'b1,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b1,4'd2,8'h2F,1'b1)); // 19
        vt.push_back(mk(1'b0,1'b0,25'h0,  8'h00,8'd0,1'b0,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b1,4'd2,8'h2F,1'b1)); // 20
        vt.push_back(mk(1'b0,1'b0,25'h0,  8'h00,8'd0,1'b0,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b1,4'd2,8'h2F,1'b1)); // 21
        vt.push_back(mk(1'b0,1'b0,25'h0,  8'h00,8'd0,1'b0,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b1,4'd2,8'h2F,1'b1)); // 22
        vt.push_back(mk(1'b0,1'b0,25'h0,  8'h00,8'd0,1'b0,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b1,4'd2,8'h2F,1'b1)); // 23
        vt.push_back(mk(1'b1,1'b0,25'h0,  8'h00,8'd0,1'b0,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b1,4'd2,8'h00,1'b0)); // 24
        vt.push_back(mk(1'b1,1'b1,25'h5,  8'h0F,8'd0,1'b1,1'b1,1'b1,25'h5,  8'h0F,1'b0,1'b1,4'd2,8'h00,1'b0)); // 25
        vt.push_back(mk(1'b0,1'b0,25'h0,  8'h00,8'd0,1'b1,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b1,4'd2,8'h0F,1'b0)); // 26
        vt.push_back(mk(1'b0,1'b0,25'h0,  8'h00,8'd0,1'b0,1'b0,1'b0,25'h0,  8'h00,1'b0,1'b1,4'd2,8'h0F,1'b0)); // 27

        // Power-up: asynchronous reset values, then idle with no download.
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_req", 32'(rom_req), 32'd0);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        RESET_N = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("idle%0d_core_reset", i), 32'(core_reset), 32'd1);
            chk($sformatf("idle%0d_req", i), 32'(rom_req), 32'd0);
            chk($sformatf("idle%0d_tno", i), 32'(tno), 32'd0);
        end

        run_vec(0, 5);
        wait_release("load_release_cycles");
        run_vec(6, 8);
        run_vec(9, 27);
        wait_release("reload_release_cycles");

        // Async reset with two entries queued and no ack pending.
        ioctl_index = 8'd0;
        ioctl_download = 1'b1;
        step();
        ioctl_wr = 1'b1; ioctl_addr = 25'h10; ioctl_dout = 8'h05; step();
        ioctl_addr = 25'h11; ioctl_dout = 8'h06; step();
        ioctl_addr = 25'h12; ioctl_dout = 8'h07; rom_ack = 1'b1; step();
        ioctl_wr = 1'b0; rom_ack = 1'b0; step();
        chk("pre_arst_req", 32'(rom_req), 32'd1);
        chk("pre_arst_checksum", 32'(checksum), 32'h05);
        chk("pre_arst_head", 32'(rom_data), 32'h06);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_req", 32'(rom_req), 32'd0);
        chk("arst_core_reset", 32'(core_reset), 32'd1);
        chk("arst_checksum", 32'(checksum), 32'd0);
        chk("arst_tno", 32'(tno), 32'd0);
        chk("arst_data", 32'(rom_data), 32'd0);
        ioctl_download = 1'b0;
        step();
        RESET_N = 1'b1;
        rom_ack = 1'b1;
        step();
        step();
        chk("post_arst_req", 32'(rom_req), 32'd0);
        chk("post_arst_checksum", 32'(checksum), 32'd0);
        chk("post_arst_core_reset", 32'(core_reset), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
